// File: rtl/pipe_reg_if.sv
// Valid/ready handshake bundle for pipe_reg.
// Covers the upstream push side, the downstream pop side and the occupancy readout.
interface pipe_reg_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [1:0]            occupancy;

    // Environment side: produces upstream entries and consumes downstream ones.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    // Pipeline stage side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/pipe_reg.sv
// Two-entry skid-buffered pipeline register with a fully registered output.
// in_ready never depends on out_ready, which breaks the ready timing path.
module pipe_reg #(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input logic       clk,
    input logic       reset,
    input logic       flush,
    pipe_reg_if.slave bus
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  in_ready;
    logic                  out_valid;
    logic                  in_fire;
    logic                  out_fire;

    assign in_ready  = (state_q != StFull) && !flush;
    assign out_valid = (state_q != StEmpty);
    assign in_fire   = bus.in_valid && in_ready;
    assign out_fire  = out_valid && bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = main_q;
    assign bus.occupancy = state_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            StEmpty: begin
                if (in_fire) begin
                    state_d = StOne;
                    main_d  = bus.in_data;
                end
            end
            StOne: begin
                if (in_fire && out_fire) begin
                    main_d = bus.in_data;
                end else if (in_fire) begin
                    state_d = StFull;
                    skid_d  = bus.in_data;
                end else if (out_fire) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                // in_ready is low here, so only the drain can happen.
                if (out_fire) begin
                    state_d = StOne;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = StEmpty;
            end
        endcase
        // Pipeline kill wins over any handshake in the same cycle.
        if (flush) begin
            state_d = StEmpty;
            main_d  = RESET_VALUE;
            skid_d  = RESET_VALUE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StEmpty;
            main_q  <= RESET_VALUE;
            skid_q  <= RESET_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_pipe_reg.sv
// Bench for pipe_reg: directed vector table on a 32-bit stage, then randomized traffic on
// 8- and 64-bit stages checked against a queue-based FIFO model.
module tb_pipe_reg;

    localparam logic [63:0] RV64 = 64'hDEAD_BEEF_0123_4567;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset32;
    logic flush32;
    logic rnd_reset;
    logic rnd_flush;

    pipe_reg_if #(.DATA_WIDTH(32)) b32 ();
    pipe_reg_if #(.DATA_WIDTH(8))  b8 ();
    pipe_reg_if #(.DATA_WIDTH(64)) b64 ();

    pipe_reg #(.DATA_WIDTH(32)) dut32 (
        .clk   (clk),
        .reset (reset32),
        .flush (flush32),
        .bus   (b32)
    );

    pipe_reg #(.DATA_WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (rnd_reset),
        .flush (rnd_flush),
        .bus   (b8)
    );

    pipe_reg #(.DATA_WIDTH(64), .RESET_VALUE(RV64)) dut64 (
        .clk   (clk),
        .reset (rnd_reset),
        .flush (rnd_flush),
        .bus   (b64)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        ov;
        logic [31:0] od;
        logic [1:0]  occ;
        logic        ir;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, fl, iv, input logic [31:0] d, input logic ordy,
                       input logic ov, input logic [31:0] od, input logic [1:0] occ,
                       input logic ir);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
        v.ov = ov; v.od = od; v.occ = occ; v.ir = ir;
        vecs.push_back(v);
    endtask

    task automatic step32();
        @(posedge clk);
        #1;
    endtask

    // Random-phase state (reference model: a plain FIFO of accepted entries)
    logic [63:0] model_q[$];
    logic        cleared;
    logic        iv, ordy, rr, rf, exp_ir, in_fire, out_fire, stall;
    logic [63:0] din, head, held;
    logic [7:0]  head8;

    initial begin
        reset32 = 1'b1; flush32 = 1'b0;
        rnd_reset = 1'b1; rnd_flush = 1'b0;
        b32.in_valid = 1'b0; b32.in_data = '0; b32.out_ready = 1'b0;
        b8.in_valid = 1'b0;  b8.in_data = '0;  b8.out_ready = 1'b0;
        b64.in_valid = 1'b0; b64.in_data = '0; b64.out_ready = 1'b0;

        //  rst fl iv data          ordy  ov od            occ ir
        add(1, 0, 0, 32'h0,         0,    0, 32'h0,        0,  1);
        add(0, 0, 1, 32'hA5A5A5A5,  1,    1, 32'hA5A5A5A5, 1,  1);
        add(0, 0, 0, 32'h0,         1,    0, 32'hA5A5A5A5, 0,  1);
        for (int k = 1; k <= 8; k++) add(0, 0, 1, k, 1, 1, k, 1, 1);
        add(0, 0, 0, 32'h0,         1,    0, 32'h8,        0,  1);
        // Backpressure: fill, hold, drain in order
        add(0, 0, 1, 32'h11,        0,    1, 32'h11,       1,  1);
        add(0, 0, 1, 32'h22,        0,    1, 32'h11,       2,  0);
        add(0, 0, 1, 32'h33,        0,    1, 32'h11,       2,  0);
        add(0, 0, 0, 32'h0,         1,    1, 32'h22,       1,  1);
        add(0, 0, 0, 32'h0,         1,    0, 32'h22,       0,  1);
        // Flush while FULL with a pending push
        add(0, 0, 1, 32'h11,        0,    1, 32'h11,       1,  1);
        add(0, 0, 1, 32'h22,        0,    1, 32'h11,       2,  0);
        add(0, 1, 1, 32'h33,        0,    0, 32'h0,        0,  0);
        add(0, 0, 0, 32'h0,         0,    0, 32'h0,        0,  1);
        // Flush coinciding with a downstream pop
        add(0, 0, 1, 32'h44,        0,    1, 32'h44,       1,  1);
        add(0, 1, 0, 32'h0,         1,    0, 32'h0,        0,  0);
        // Reset and flush together in ONE
        add(0, 0, 1, 32'h55,        0,    1, 32'h55,       1,  1);
        add(1, 1, 1, 32'h66,        1,    0, 32'h0,        0,  0);
        add(0, 0, 0, 32'h0,         0,    0, 32'h0,        0,  1);
        // Reset from FULL, then first push after release
        add(0, 0, 1, 32'h77,        0,    1, 32'h77,       1,  1);
        add(0, 0, 1, 32'h88,        0,    1, 32'h77,       2,  0);
        add(1, 0, 0, 32'h0,         0,    0, 32'h0,        0,  1);
        add(0, 0, 1, 32'h99,        1,    1, 32'h99,       1,  1);

        foreach (vecs[i]) begin
            reset32       = vecs[i].rst;
            flush32       = vecs[i].fl;
            b32.in_valid  = vecs[i].iv;
            b32.in_data   = vecs[i].d;
            b32.out_ready = vecs[i].ordy;
            step32();
            chk($sformatf("vec%0d out_valid", i), 64'(b32.out_valid), 64'(vecs[i].ov));
            chk($sformatf("vec%0d out_data", i), 64'(b32.out_data), 64'(vecs[i].od));
            chk($sformatf("vec%0d occupancy", i), 64'(b32.occupancy), 64'(vecs[i].occ));
            chk($sformatf("vec%0d in_ready", i), 64'(b32.in_ready), 64'(vecs[i].ir));
        end

        // Hand sequence: FULL stall stability and ready independence from out_ready
        b32.in_valid = 1'b0; b32.out_ready = 1'b1;
        step32();
        chk("seq drained", 64'(b32.occupancy), 64'd0);
        b32.in_valid = 1'b1; b32.in_data = 32'hAA; b32.out_ready = 1'b0;
        step32();
        b32.in_data = 32'hBB;
        step32();
        b32.in_valid = 1'b0; b32.out_ready = 1'b1;
        #1;
        chk("seq full in_ready with out_ready=1", 64'(b32.in_ready), 64'd0);
        b32.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step32();
            chk($sformatf("seq stall%0d out_data", k), 64'(b32.out_data), 64'hAA);
            chk($sformatf("seq stall%0d occupancy", k), 64'(b32.occupancy), 64'd2);
        end
        b32.out_ready = 1'b1;
        step32();
        chk("seq drain1 out_data", 64'(b32.out_data), 64'hBB);
        step32();
        chk("seq drain2 out_valid", 64'(b32.out_valid), 64'd0);
        flush32 = 1'b1; b32.in_valid = 1'b1; b32.in_data = 32'hCC;
        #1;
        chk("seq flush in_ready", 64'(b32.in_ready), 64'd0);
        step32();
        chk("seq flush no accept", 64'(b32.occupancy), 64'd0);
        flush32 = 1'b0; b32.in_valid = 1'b0;

        // Random traffic on the 8- and 64-bit stages
        rnd_reset = 1'b1;
        @(posedge clk);
        #1;
        rnd_reset = 1'b0;
        model_q.delete();
        cleared = 1'b1;
        chk("rnd reset out_data64", b64.out_data, RV64);
        for (int c = 0; c < 10000; c++) begin
            iv   = ($urandom_range(0, 99) < 70);
            ordy = ($urandom_range(0, 99) < (((c / 500) % 2 == 1) ? 85 : 35));
            din  = {$urandom, $urandom};
            rr   = ($urandom_range(0, 999) < 3);
            rf   = ($urandom_range(0, 999) < 10);
            rnd_reset = rr; rnd_flush = rf;
            b8.in_valid = iv;  b8.in_data = din[7:0];  b8.out_ready = ordy;
            b64.in_valid = iv; b64.in_data = din;      b64.out_ready = ordy;
            #1;
            exp_ir   = (model_q.size() < 2) && !rf;
            chk("rnd in_ready8", 64'(b8.in_ready), 64'(exp_ir));
            chk("rnd in_ready64", 64'(b64.in_ready), 64'(exp_ir));
            in_fire  = iv && exp_ir;
            out_fire = (model_q.size() > 0) && ordy;
            stall    = (model_q.size() > 0) && !ordy && !rr && !rf;
            held     = (model_q.size() > 0) ? model_q[0] : 64'h0;
            @(posedge clk);
            #1;
            if (rr || rf) begin
                model_q.delete();
                cleared = 1'b1;
            end else begin
                if (out_fire) begin
                    void'(model_q.pop_front());
                    cleared = 1'b0;
                end
                if (in_fire) begin
                    model_q.push_back(din);
                    cleared = 1'b0;
                end
            end
            chk("rnd occupancy8", 64'(b8.occupancy), 64'(model_q.size()));
            chk("rnd occupancy64", 64'(b64.occupancy), 64'(model_q.size()));
            chk("rnd out_valid8", 64'(b8.out_valid), 64'(model_q.size() > 0));
            chk("rnd out_valid64", 64'(b64.out_valid), 64'(model_q.size() > 0));
            if (model_q.size() > 0) begin
                head  = model_q[0];
                head8 = head[7:0];
                chk("rnd out_data8", 64'(b8.out_data), 64'(head8));
                chk("rnd out_data64", b64.out_data, head);
            end else if (cleared) begin
                chk("rnd cleared out_data8", 64'(b8.out_data), 64'h0);
                chk("rnd cleared out_data64", b64.out_data, RV64);
            end
            if (stall) begin
                chk("rnd stall out_data64", b64.out_data, held);
                chk("rnd stall out_valid64", 64'(b64.out_valid), 64'd1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_reg.md
PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 Parameter DATA_WIDTH, default 32: payload width in bits, legal range 1..1024.
REQ-002 Parameter RESET_VALUE, default all-zeros (DATA_WIDTH bits): value loaded into both data registers on reset and flush.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  synchronous discard of all held entries (pipeline kill).
REQ-006 in_valid  input  1  upstream presents in_data.
REQ-007 in_ready  output  1  stage can accept an entry this cycle.
REQ-008 in_data  input  DATA_WIDTH  upstream payload.
REQ-009 out_valid  output  1  out_data holds a valid entry.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 out_data  output  DATA_WIDTH  payload of the oldest held entry.
REQ-012 occupancy  output  2  number of held entries, 0..2.

Function
REQ-013 Storage: a main register (drives out_data) and a skid register; a state register holds EMPTY(0), ONE(1) or FULL(2).
REQ-014 in_fire = in_valid && in_ready; out_fire = out_valid && out_ready.
REQ-015 in_ready = (state != FULL) && !flush; it does not depend on out_ready (no ready combinational path in-to-out).
REQ-016 out_valid = (state != EMPTY); out_data = main register; occupancy = state encoding; all three are driven only from registers.
REQ-017 EMPTY: in_fire -> ONE, main <= in_data; otherwise stay.
REQ-018 ONE: in_fire and out_fire -> ONE, main <= in_data; in_fire only -> FULL, skid <= in_data; out_fire only -> EMPTY; neither -> stay.
REQ-019 FULL: out_fire -> ONE, main <= skid; otherwise stay; in_fire cannot occur.
REQ-020 Latency: an entry accepted at edge N is visible on out_data/out_valid after edge N (zero bubbles); sustained throughput is one entry per cycle when out_ready stays high.
REQ-021 Ordering: entries leave in exact acceptance order; no entry is duplicated or dropped except by flush or reset.
REQ-022 Stability: while out_valid && !out_ready, out_data and out_valid do not change.
REQ-023 Flush: state <= EMPTY, main and skid <= RESET_VALUE; flush overrides any simultaneous in_fire/out_fire update; in_ready is 0 during flush, so nothing is accepted in that cycle.
REQ-024 A downstream out_fire in the flush cycle counts as delivered downstream; the stage still ends EMPTY.
REQ-025 Skid register contents are don't-care outside FULL, but follow REQ-023/REQ-026 values.

Reset
REQ-026 reset has priority over flush and all handshakes: state <= EMPTY, main and skid <= RESET_VALUE.
REQ-027 Outputs after a reset edge: out_valid=0, out_data=RESET_VALUE, occupancy=0, in_ready=1 (flush low).
REQ-028 Reset mid-transfer (any state) discards held entries with no partial update; the first in_fire after reset release is accepted normally.

Verification
REQ-029 Reset then in_valid=1, in_data=0xA5A5A5A5, out_ready=1 for one cycle -> next cycle out_valid=1, out_data=0xA5A5A5A5, occupancy=1; following cycle (in_valid=0) out_valid=0.
REQ-030 Stream 0x1..0x8 with out_ready=1 continuously -> 0x1..0x8 appear on consecutive cycles, one cycle after acceptance, in_ready constantly 1.
REQ-031 out_ready=0, push 0x11 then 0x22 -> occupancy=2, in_ready=0, out_data=0x11 held; raise out_ready -> 0x11 then 0x22 delivered, then occupancy=0.
REQ-032 State FULL (0x11, 0x22), assert flush with in_valid=1, in_data=0x33 -> next cycle occupancy=0, out_valid=0, out_data=RESET_VALUE, 0x33 not accepted.
REQ-033 State ONE, assert reset and flush together with in_valid=1 -> next cycle EMPTY, out_data=RESET_VALUE, in_ready=1.
REQ-034 Random in_valid/out_ready (10k cycles, DATA_WIDTH=8 and 64) against a reference FIFO model -> order preserved, no loss, REQ-022 holds every cycle, occupancy never exceeds 2.
